// File: rtl/dshot_pkg.sv
// rtl/dshot_pkg.sv - DSHOT frame encoder types, widths and timing/CRC helpers
package dshot_pkg;

    localparam int DSHOT_FRAME_W = 16;
    localparam int DSHOT_VAL_W   = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } dshot_state_t;

    function automatic int dshot_bit_period(input int clk_hz, input int rate_k);
        return clk_hz / (rate_k * 1000);
    endfunction

    function automatic int dshot_t1h(input int t);
        return t * 3 / 4;
    endfunction

    function automatic int dshot_t0h(input int t);
        return t * 3 / 8;
    endfunction

    // XOR of the three nibbles of {value, telemetry}
    function automatic logic [3:0] dshot_crc(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

    function automatic logic [DSHOT_FRAME_W-1:0] dshot_frame(
        input logic [DSHOT_VAL_W-1:0] thr,
        input logic                   telem
    );
        logic [11:0] v;
        v = {thr, telem};
        return {v, dshot_crc(v)};
    endfunction

endpackage

// File: rtl/dshot_tx.sv
// rtl/dshot_tx.sv - single-channel DSHOT frame encoder with repeat and inter-frame gap
module dshot_tx
    import dshot_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int DSHOT_RATE_K = 600,
    parameter int GAP_BITS     = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [DSHOT_VAL_W-1:0] throttle_i,
    input  logic                   telem_i,
    input  logic                   repeat_en_i,
    output logic                   dshot_o,
    output logic                   busy_o,
    output logic                   frame_done_o
);

    localparam int T       = dshot_bit_period(CLK_FREQ_HZ, DSHOT_RATE_K);
    localparam int T1H     = dshot_t1h(T);
    localparam int T0H     = dshot_t0h(T);
    localparam int GAP     = GAP_BITS * T;
    localparam int CNT_MAX = (T > GAP) ? T : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LD_H1   = CW'(T1H - 1);
    localparam logic [CW-1:0] LD_H0   = CW'(T0H - 1);
    localparam logic [CW-1:0] LD_L1   = CW'(T - T1H - 1);
    localparam logic [CW-1:0] LD_L0   = CW'(T - T0H - 1);
    localparam logic [CW-1:0] LD_GAP  = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (T < 8) begin : g_rate_check
        $error("dshot_tx: bit period must be at least 8 clocks");
    end

    if (GAP_BITS < 1) begin : g_gap_check
        $error("dshot_tx: GAP_BITS must be at least 1");
    end

    dshot_state_t             state, state_d;
    logic [CW-1:0]            cnt, cnt_d;
    logic [DSHOT_FRAME_W-1:0] shreg, shreg_d;
    logic [DSHOT_FRAME_W-1:0] last_frame, last_frame_d;
    logic [DSHOT_FRAME_W-1:0] new_frame;
    logic [3:0]               bit_idx, bit_idx_d;
    logic                     have_last, have_last_d;
    logic                     gap_end;
    logic                     done_q;

    function automatic logic [CW-1:0] high_load(input logic b);
        return b ? LD_H1 : LD_H0;
    endfunction

    assign new_frame   = dshot_frame(throttle_i, telem_i);
    assign cmd_ready_o = (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        shreg_d      = shreg;
        bit_idx_d    = bit_idx;
        last_frame_d = last_frame;
        have_last_d  = have_last;
        gap_end      = 1'b0;

        case (state)
            ST_IDLE: begin
                // A fresh command always wins over retransmitting the old one
                if (cmd_valid_i) begin
                    shreg_d      = new_frame;
                    last_frame_d = new_frame;
                    have_last_d  = 1'b1;
                    cnt_d        = high_load(new_frame[DSHOT_FRAME_W-1]);
                    state_d      = ST_HIGH;
                end else if (repeat_en_i && have_last) begin
                    shreg_d = last_frame;
                    cnt_d   = high_load(last_frame[DSHOT_FRAME_W-1]);
                    state_d = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (cnt == '0) begin
                    cnt_d   = shreg[DSHOT_FRAME_W-1] ? LD_L1 : LD_L0;
                    state_d = ST_LOW;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end

            ST_LOW: begin
                if (cnt == '0) begin
                    if (bit_idx == 4'd15) begin
                        cnt_d   = LD_GAP;
                        state_d = ST_GAP;
                    end else begin
                        shreg_d   = shreg << 1;
                        bit_idx_d = bit_idx + 4'd1;
                        cnt_d     = high_load(shreg[DSHOT_FRAME_W-2]);
                        state_d   = ST_HIGH;
                    end
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end

            ST_GAP: begin
                if (cnt == '0) begin
                    bit_idx_d = bit_idx + 4'd1;
                    gap_end   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // The line and the done pulse both trail the state by one clock so the
    // pulse marks the end of the gap as it appears on the wire.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            shreg        <= '0;
            last_frame   <= '0;
            bit_idx      <= '0;
            have_last    <= 1'b0;
            dshot_o      <= 1'b0;
            done_q       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            shreg        <= shreg_d;
            last_frame   <= last_frame_d;
            bit_idx      <= bit_idx_d;
            have_last    <= have_last_d;
            dshot_o      <= (state == ST_HIGH);
            done_q       <= gap_end;
            frame_done_o <= done_q;
        end
    end

endmodule

// File: tb/tb_dshot_tx.sv
// tb/tb_dshot_tx.sv - self-checking bench for dshot_tx
module tb_dshot_tx;

    localparam int T      = 166;
    localparam int T1H    = 124;
    localparam int T0H    = 62;
    localparam int GAP    = 332;
    localparam int DONE_K = 16 * T + GAP + 1;   // accept edge to frame_done_o
    localparam int PERIOD = 16 * T + GAP + 1;   // 2989

    logic        wb_clk    = 1'b0;
    logic        wb_rst    = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        telem     = 1'b0;
    logic        repeat_en = 1'b0;
    logic [10:0] throttle  = '0;
    logic        cmd_ready, dshot, busy, frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    dshot_tx #(
        .CLK_FREQ_HZ (100_000_000),
        .DSHOT_RATE_K(600),
        .GAP_BITS    (2)
    ) dut (
        .wb_clk_i    (wb_clk),
        .wb_rst_i    (wb_rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .throttle_i  (throttle),
        .telem_i     (telem),
        .repeat_en_i (repeat_en),
        .dshot_o     (dshot),
        .busy_o      (busy),
        .frame_done_o(frame_done)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input bit cond, input string nm, input longint act, input longint exp);
        total++;
        if (!cond) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic eq(input string nm, input longint act, input longint exp);
        check(act == exp, nm, act, exp);
    endtask

    function automatic logic [15:0] spec_frame(input int thr, input int tel);
        int v, c;
        v = thr * 2 + tel;
        c = (v ^ (v >> 4) ^ (v >> 8)) & 15;
        return 16'(v * 16 + c);
    endfunction

    // Timeline model: when frames were accepted and what they carry
    int          m_acc  = -1;
    int          m_prev = -1;
    logic [15:0] m_frame = '0;
    logic [15:0] m_last  = '0;
    bit          m_have  = 1'b0;

    always @(posedge wb_clk) begin
        cyc++;
        if (wb_rst) begin
            m_acc  = -1;
            m_prev = -1;
            m_have = 1'b0;
        end else if (m_acc < 0 || cyc - m_acc >= PERIOD) begin
            if (cmd_valid) begin
                m_prev  = m_acc;
                m_acc   = cyc;
                m_frame = spec_frame(int'(throttle), int'(telem));
                m_last  = m_frame;
                m_have  = 1'b1;
            end else if (repeat_en && m_have) begin
                m_prev  = m_acc;
                m_acc   = cyc;
                m_frame = m_last;
            end
        end
    end

    always @(negedge wb_clk) begin : cmp
        int j;
        bit b, e_dshot, e_ready, e_done;
        if (chk_en) begin
            e_ready = (m_acc < 0) || (cyc - m_acc >= PERIOD - 1);
            e_dshot = 1'b0;
            if (m_acc >= 0) begin
                j = cyc - m_acc - 1;
                if (j >= 0 && j < 16 * T) begin
                    b       = m_frame[15 - j / T];
                    e_dshot = (j % T) < (b ? T1H : T0H);
                end
            end
            e_done = (m_acc >= 0 && cyc - m_acc == DONE_K) ||
                     (m_prev >= 0 && cyc - m_prev == DONE_K);
            eq("dshot_o", dshot, e_dshot);
            eq("cmd_ready_o", cmd_ready, e_ready);
            eq("busy_o", busy, !e_ready);
            eq("frame_done_o", frame_done, e_done);
        end
    end

    // Line decoder: recovers frames, start cycles and done pulses
    int          start_q[$];
    int          done_q[$];
    logic [15:0] dec_q[$];
    int          last_rise = 0;
    int          nbits     = 0;
    logic [15:0] word      = '0;
    logic        prev_d    = 1'b0;

    always @(negedge wb_clk) begin : dec
        int w;
        if (chk_en) begin
            if (wb_rst) begin
                nbits  = 0;
                prev_d = 1'b0;
            end else begin
                if (dshot && !prev_d) begin
                    if (nbits == 0) start_q.push_back(cyc);
                    else eq("bit period", cyc - last_rise, T);
                    last_rise = cyc;
                end
                if (!dshot && prev_d) begin
                    w = cyc - last_rise;
                    check(w == T1H || w == T0H, "high width", w, T1H);
                    word = {word[14:0], (w == T1H)};
                    nbits++;
                    if (nbits == 16) begin
                        dec_q.push_back(word);
                        nbits = 0;
                    end
                end
                if (frame_done) done_q.push_back(cyc);
                prev_d = dshot;
            end
        end
    end

    function automatic int s_at(input int i);
        return (i < start_q.size()) ? start_q[i] : -100000;
    endfunction

    function automatic int d_at(input int i);
        return (i < done_q.size()) ? done_q[i] : -100000;
    endfunction

    function automatic int w_at(input int i);
        return (i < dec_q.size()) ? int'(dec_q[i]) : -1;
    endfunction

    task automatic step();
        @(negedge wb_clk);
        #1;
    endtask

    task automatic clear_q();
        start_q.delete();
        done_q.delete();
        dec_q.delete();
    endtask

    task automatic send_hold(input int thr, input bit tel, input bit drop, input string nm);
        int i;
        throttle  = 11'(thr);
        telem     = tel;
        cmd_valid = 1'b1;
        i = 0;
        while (!cmd_ready && i < 8000) begin
            step();
            i++;
        end
        eq({nm, " ready seen"}, cmd_ready, 1);
        step();
        eq({nm, " accepted"}, cmd_ready, 0);
        if (drop) cmd_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n, input string nm);
        int i;
        i = 0;
        while (start_q.size() < n && i < 12000) begin
            step();
            i++;
        end
        check(start_q.size() >= n, nm, start_q.size(), n);
    endtask

    task automatic wait_dones(input int n, input string nm);
        int i;
        i = 0;
        while (done_q.size() < n && i < 12000) begin
            step();
            i++;
        end
        check(done_q.size() >= n, nm, done_q.size(), n);
    endtask

    initial begin
        repeat (3) @(negedge wb_clk);
        #1;
        wb_rst = 1'b0;
        chk_en = 1'b1;
        eq("reset dshot_o", dshot, 0);
        eq("reset cmd_ready_o", cmd_ready, 1);
        eq("reset busy_o", busy, 0);
        eq("reset frame_done_o", frame_done, 0);
        step();

        // Single throttle frame
        clear_q();
        send_hold(1046, 1'b0, 1'b1, "t1");
        wait_dones(1, "t1 done");
        eq("t1 word", w_at(0), 16'h82C6);
        eq("t1 done after rise", d_at(0) - s_at(0), 2988);

        // Lowest throttle with telemetry
        clear_q();
        send_hold(48, 1'b1, 1'b1, "t2");
        repeat (2000) step();
        eq("t2 busy mid", busy, 1);
        eq("t2 ready mid", cmd_ready, 0);
        wait_dones(1, "t2 done");
        eq("t2 word", w_at(0), 16'h0617);

        // All-zero frame
        clear_q();
        send_hold(0, 1'b0, 1'b1, "t3");
        wait_dones(1, "t3 done");
        eq("t3 word", w_at(0), 16'h0000);

        // Back-to-back with valid held; inputs change mid-frame
        clear_q();
        send_hold(500, 1'b0, 1'b0, "b2b a");
        send_hold(1234, 1'b1, 1'b1, "b2b b");
        wait_dones(2, "b2b done");
        eq("b2b word a", w_at(0), 16'h3E85);
        eq("b2b word b", w_at(1), 16'h9A56);
        eq("b2b restart", s_at(1) - d_at(0), 1);

        // Repeat mode, then a new command replacing the repeat
        clear_q();
        send_hold(1046, 1'b0, 1'b1, "rp");
        repeat_en = 1'b1;
        wait_starts(3, "rp starts");
        repeat (1000) step();
        send_hold(48, 1'b1, 1'b1, "rp new");
        wait_starts(5, "rp starts new");
        repeat (500) step();
        repeat_en = 1'b0;
        wait_dones(5, "rp done");
        repeat (3500) step();
        eq("rp frame count", start_q.size(), 5);
        eq("rp word 0", w_at(0), 16'h82C6);
        eq("rp word 1", w_at(1), 16'h82C6);
        eq("rp word 2", w_at(2), 16'h82C6);
        eq("rp word 3", w_at(3), 16'h0617);
        eq("rp word 4", w_at(4), 16'h0617);
        for (int i = 1; i < 5; i++) eq("rp period", s_at(i) - s_at(i - 1), PERIOD);

        // Reset during bit 7 with repeat enabled
        clear_q();
        send_hold(1046, 1'b0, 1'b1, "rst");
        repeat_en = 1'b1;
        wait_starts(1, "rst start");
        repeat (7 * T + 30) step();
        eq("rst bit7 high", dshot, 1);
        wb_rst = 1'b1;
        step();
        eq("rst dshot_o", dshot, 0);
        eq("rst cmd_ready_o", cmd_ready, 1);
        eq("rst busy_o", busy, 0);
        wb_rst = 1'b0;
        repeat (4000) step();
        eq("rst no repeat", start_q.size(), 1);
        eq("rst no done", done_q.size(), 0);
        repeat_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dshot_tx.md
Name: dshot_tx

Overview:
Single-channel DSHOT frame encoder. It accepts throttle/telemetry commands over a valid/ready handshake, builds the 16-bit DSHOT frame (11-bit value, telemetry bit, 4-bit CRC) and emits the pulse-width-coded bitstream. Four instances feed dshot_in[3:0] of wb_serial_dshot_mux, which routes them to the motor pads when DSHOT mode is selected.

Parameters:
CLK_FREQ_HZ, 100_000_000, wb_clk_i frequency in Hz
DSHOT_RATE_K, 600, bit rate in kbit/s (150/300/600/1200)
GAP_BITS, 2, minimum low inter-frame gap, in bit periods

Ports:
wb_clk_i  input  1  system clock; single clock domain
wb_rst_i  input  1  synchronous, active-high reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  block can accept a command
throttle_i  input  11  DSHOT value (0-47 commands, 48-2047 throttle)
telem_i  input  1  telemetry request bit
repeat_en_i  input  1  retransmit last frame when no new command is pending
dshot_o  output  1  encoded line (registered) to mux dshot_in[n]
busy_o  output  1  frame or gap in progress
frame_done_o  output  1  one-cycle pulse when the gap completes

Behaviour:
- Localparams (integer truncation):
  - T = CLK_FREQ_HZ/(DSHOT_RATE_K*1000)
  - T1H = T*3/4
  - T0H = T*3/8
  - GAP = GAP_BITS*T
  - Elaboration error if T < 8.
  - At defaults: T=166, T1H=124, T0H=62, GAP=332.
- Frame:
  - v = {throttle_i, telem_i} (12b).
  - crc = (v ^ v>>4 ^ v>>8) & 4'hF.
  - frame = {v, crc}, sent MSB first.
- Reset values: dshot_o=0, cmd_ready_o=1, busy_o=0, frame_done_o=0, last-frame register cleared, have_last=0.
- FSM states: IDLE, HIGH, LOW, GAP.
  - IDLE: cmd_ready_o=1. On cmd_valid_i&&cmd_ready_o at edge N: latch the frame into the shift register and into last-frame, set have_last=1, go to HIGH. dshot_o=1 from edge N+1 (one-cycle latency).
  - IDLE with no valid command, repeat_en_i=1 and have_last=1: reload last-frame and go to HIGH.
  - HIGH: dshot_o=1 for exactly T1H cycles (bit=1) or T0H cycles (bit=0), then go to LOW.
  - LOW: dshot_o=0 for T-T1H or T-T0H cycles, so every bit is exactly T cycles. Then shift; after bit 15 go to GAP.
  - GAP: dshot_o=0 for GAP cycles. On exit, pulse frame_done_o and return to IDLE.
- cmd_ready_o is high only in IDLE. Commands presented while busy are held off; the upstream keeps valid asserted.
- busy_o=1 in HIGH/LOW/GAP.
- A new valid command has priority over a repeat in the same IDLE cycle.
- Minimum frame-to-frame period is 16*T+GAP+1 cycles (2989 at defaults).
- Inputs are sampled only on the accept edge; changes mid-frame have no effect on the frame in flight.
- Reset mid-frame: dshot_o=0 on the next edge, FSM to IDLE, have_last cleared, no frame_done_o pulse.
- repeat_en_i deasserted mid-frame: the current frame completes and no repeat follows.
- Counters:
  - Single down-counter sized $clog2(max(T,GAP)+1).
  - 4-bit bit index; wraps only through a GAP→IDLE transition.

Decomposition:
- Package dshot_pkg:
  - dshot_state_t enum
  - DSHOT_FRAME_W=16, DSHOT_VAL_W=11
  - function dshot_crc(12b)→4b
  - timing helper functions (bit period, T1H, T0H from clock/rate)
- Sub-module: none needed. A 4-channel wrapper (dshot_tx_quad) instantiates four dshot_tx and drives dshot_in[3:0].

Test Plan:
- Reset, then throttle_i=1046, telem_i=0, single valid pulse → accept in 1 cycle; bitstream decodes to 16'h82C6; high times are 124 (ones) and 62 (zeros); every bit is 166 cycles; frame_done_o pulses 2656+332 cycles after the first rise.
- throttle_i=48, telem_i=1 → frame 16'h0617; busy_o=1 throughout; cmd_ready_o=0 until the gap ends.
- throttle_i=0, telem_i=0 → 16 pulses of 62 high / 104 low; dshot_o stays 0 through the 332-cycle gap.
- Back-to-back: cmd_valid_i held high with new values → second frame starts exactly 1 cycle after frame_done_o; no overlap; values are latched only on accept edges.
- repeat_en_i=1 after one command (1046), no further valid → 16'h82C6 repeats with a 2989-cycle period. Assert valid with 48/1 mid-frame → the new frame replaces the repeat at the next IDLE.
- wb_rst_i asserted during bit 7 → dshot_o=0 and cmd_ready_o=1 next edge; with repeat_en_i=1, no retransmission occurs (have_last cleared).
